// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: fixed priority to source A (ALU writeback)
// with a starvation guard that forces one grant to source B (multi-cycle unit)
// after MAX_WAIT consecutive refusals. Write bundle is registered (1-cycle latency).
module wb_port_arbiter #(
   parameter int unsigned DW       = 32,
   parameter int unsigned AW       = 5,
   parameter int unsigned MAX_WAIT = 4,
   parameter int unsigned CW       = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          a_valid,
   input  logic [AW-1:0] a_rd,
   input  logic [DW-1:0] a_data,
   output logic          a_ready,
   input  logic          b_valid,
   input  logic [AW-1:0] b_rd,
   input  logic [DW-1:0] b_data,
   output logic          b_ready,
   output logic          mux_sel,
   output logic          wb_en,
   output logic [AW-1:0] wb_rd,
   output logic [DW-1:0] wb_data,
   output logic [CW-1:0] conflict_cnt
);

   localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

   typedef enum logic {StPrioA, StForceB} state_e;

   state_e        state_q, state_d;
   logic [3:0]    starve_q, starve_d;
   logic          wb_en_q, wb_en_d;
   logic [AW-1:0] wb_rd_q, wb_rd_d;
   logic [DW-1:0] wb_data_q, wb_data_d;
   logic [CW-1:0] conflict_q, conflict_d;

   // Same-cycle grant; the forced state only overrides A while B is still asking
   always_comb begin
      a_ready = 1'b0;
      b_ready = 1'b0;
      if (state_q == StForceB && b_valid) begin
         b_ready = 1'b1;
      end else if (a_valid) begin
         a_ready = 1'b1;
      end else if (b_valid) begin
         b_ready = 1'b1;
      end
      mux_sel = a_ready;
   end

   // Starvation tracking and force-B state selection
   always_comb begin
      starve_d = 4'd0;
      if (b_valid && !b_ready) begin
         starve_d = (starve_q >= MaxWait) ? MaxWait : starve_q + 4'd1;
      end
      state_d = state_q;
      unique case (state_q)
         StPrioA:  if (starve_d == MaxWait) state_d = StForceB;
         StForceB: if (b_ready || !b_valid) state_d = StPrioA;
         default:  state_d = StPrioA;
      endcase
   end

   // Next write bundle and saturating conflict counter
   always_comb begin
      wb_en_d   = 1'b0;
      wb_rd_d   = wb_rd_q;
      wb_data_d = wb_data_q;
      if (a_valid && a_ready) begin
         wb_rd_d   = a_rd;
         wb_data_d = a_data;
         wb_en_d   = (a_rd != '0);
      end else if (b_valid && b_ready) begin
         wb_rd_d   = b_rd;
         wb_data_d = b_data;
         wb_en_d   = (b_rd != '0);
      end
      conflict_d = conflict_q;
      if (a_valid && b_valid && conflict_q != '1) begin
         conflict_d = conflict_q + 1'b1;
      end
   end

   // All state on the rising edge; reset drops any pending write immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StPrioA;
         starve_q   <= 4'd0;
         wb_en_q    <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
         conflict_q <= '0;
      end else begin
         state_q    <= state_d;
         starve_q   <= starve_d;
         wb_en_q    <= wb_en_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
         conflict_q <= conflict_d;
      end
   end

   assign wb_en        = wb_en_q;
   assign wb_rd        = wb_rd_q;
   assign wb_data      = wb_data_q;
   assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter (conflict counter narrowed to 4 bits).
module tb_wb_port_arbiter;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;
   localparam int unsigned CW = 4;

   logic          clk;
   logic          rst_n;
   logic          a_valid, b_valid;
   logic [AW-1:0] a_rd, b_rd;
   logic [DW-1:0] a_data, b_data;
   logic          a_ready, b_ready, mux_sel, wb_en;
   logic [AW-1:0] wb_rd;
   logic [DW-1:0] wb_data;
   logic [CW-1:0] conflict_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   wb_port_arbiter #(
      .DW       (DW),
      .AW       (AW),
      .MAX_WAIT (4),
      .CW       (CW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .a_valid      (a_valid),
      .a_rd         (a_rd),
      .a_data       (a_data),
      .a_ready      (a_ready),
      .b_valid      (b_valid),
      .b_rd         (b_rd),
      .b_data       (b_data),
      .b_ready      (b_ready),
      .mux_sel      (mux_sel),
      .wb_en        (wb_en),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .conflict_cnt (conflict_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      a_valid = 1'b0; a_rd = '0; a_data = '0;
      b_valid = 1'b0; b_rd = '0; b_data = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle_inputs();
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      n_checks++;
      if (a_ready !== 1'b0 || b_ready !== 1'b0 || mux_sel !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle_grant: a_ready=%b b_ready=%b mux_sel=%b required 0 0 0",
                  a_ready, b_ready, mux_sel);
      end
      // Build up non-zero state, then reset mid-cycle with A still valid
      a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hCAFE_0001;
      b_valid = 1'b1; b_rd = 5'd6; b_data = 32'h0BAD_0002;
      tick();
      tick();
      n_checks++;
      if (wb_en !== 1'b1 || conflict_cnt !== 4'd2) begin
         n_fail++;
         $display("FAIL reset_prefill: wb_en=%b conflict_cnt=%0d required 1 2",
                  wb_en, conflict_cnt);
      end
      b_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (wb_en !== 1'b0 || wb_rd !== '0 || wb_data !== '0 || conflict_cnt !== '0) begin
         n_fail++;
         $display("FAIL reset_async: wb_en=%b wb_rd=%0d wb_data=%h conflict=%0d required 0 0 0 0",
                  wb_en, wb_rd, wb_data, conflict_cnt);
      end
      idle_inputs();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_a_only();
      a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h1234_5678;
      #1;
      n_checks++;
      if (a_ready !== 1'b1 || b_ready !== 1'b0 || mux_sel !== 1'b1) begin
         n_fail++;
         $display("FAIL a_only_grant: a_ready=%b b_ready=%b mux_sel=%b required 1 0 1",
                  a_ready, b_ready, mux_sel);
      end
      tick();
      idle_inputs();
      n_checks++;
      if (wb_en !== 1'b1 || wb_rd !== 5'd3 || wb_data !== 32'h1234_5678) begin
         n_fail++;
         $display("FAIL a_only_wb: wb_en=%b wb_rd=%0d wb_data=%h required 1 3 12345678",
                  wb_en, wb_rd, wb_data);
      end
      tick();
   endtask

   task automatic test_starvation();
      a_valid = 1'b1; a_rd = 5'd9; a_data = 32'h0000_AAAA;
      b_valid = 1'b1; b_rd = 5'd7; b_data = 32'hDEAD_BEEF;
      for (int c = 0; c < 6; c++) begin
         #1;
         n_checks++;
         if (c == 4) begin
            if (b_ready !== 1'b1 || a_ready !== 1'b0 || mux_sel !== 1'b0) begin
               n_fail++;
               $display("FAIL starve_force c=%0d: a_ready=%b b_ready=%b mux_sel=%b required 0 1 0",
                        c, a_ready, b_ready, mux_sel);
            end
         end else begin
            if (a_ready !== 1'b1 || b_ready !== 1'b0 || mux_sel !== 1'b1) begin
               n_fail++;
               $display("FAIL starve_agrant c=%0d: a_ready=%b b_ready=%b mux_sel=%b required 1 0 1",
                        c, a_ready, b_ready, mux_sel);
            end
         end
         n_checks++;
         if (conflict_cnt !== 4'(c)) begin
            n_fail++;
            $display("FAIL starve_conflict c=%0d: conflict_cnt=%0d required %0d",
                     c, conflict_cnt, c);
         end
         if (c == 5) begin
            n_checks++;
            if (wb_en !== 1'b1 || wb_rd !== 5'd7 || wb_data !== 32'hDEAD_BEEF) begin
               n_fail++;
               $display("FAIL starve_bwrite: wb_en=%b wb_rd=%0d wb_data=%h required 1 7 deadbeef",
                        wb_en, wb_rd, wb_data);
            end
         end
         tick();
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_reg0();
      b_valid = 1'b1; b_rd = 5'd0; b_data = 32'h5555_AAAA;
      #1;
      n_checks++;
      if (b_ready !== 1'b1 || a_ready !== 1'b0 || mux_sel !== 1'b0) begin
         n_fail++;
         $display("FAIL reg0_grant: a_ready=%b b_ready=%b mux_sel=%b required 0 1 0",
                  a_ready, b_ready, mux_sel);
      end
      tick();
      idle_inputs();
      n_checks++;
      if (wb_en !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'h5555_AAAA) begin
         n_fail++;
         $display("FAIL reg0_suppress: wb_en=%b wb_rd=%0d wb_data=%h required 0 0 5555aaaa",
                  wb_en, wb_rd, wb_data);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic          exp_en;
      logic [AW-1:0] exp_rd;
      for (int i = 0; i < 5; i++) begin
         if (i < 3) begin
            a_valid = 1'b1; a_rd = 5'(i + 1); a_data = 32'hA0 + 32'(i);
         end else begin
            idle_inputs();
         end
         #1;
         if (i >= 1) begin
            exp_en = (i <= 3);
            exp_rd = (i <= 3) ? 5'(i) : 5'd3;
            n_checks++;
            if (wb_en !== exp_en || wb_rd !== exp_rd) begin
               n_fail++;
               $display("FAIL b2b c=%0d: wb_en=%b wb_rd=%0d required %b %0d",
                        i, wb_en, wb_rd, exp_en, exp_rd);
            end
         end
         tick();
      end
   endtask

   task automatic test_saturation();
      logic [CW-1:0] exp_cnt;
      do_reset();
      a_valid = 1'b1; a_rd = 5'd1; a_data = 32'h1;
      b_valid = 1'b1; b_rd = 5'd2; b_data = 32'h2;
      for (int i = 1; i <= 20; i++) begin
         tick();
         exp_cnt = (i > 15) ? 4'd15 : 4'(i);
         n_checks++;
         if (conflict_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL sat_conflict cycle=%0d: conflict_cnt=%0d required %0d",
                     i, conflict_cnt, exp_cnt);
         end
      end
      idle_inputs();
      tick();
      n_checks++;
      if (conflict_cnt !== 4'd15) begin
         n_fail++;
         $display("FAIL sat_hold: conflict_cnt=%0d required 15", conflict_cnt);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      test_reset();
      test_a_only();
      test_starvation();
      test_reg0();
      test_back_to_back();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
